tile_l1_bank_mux: RTL and testbench

Request-side front end of the tile's banked L1 scratchpad. It takes the core's instruction-fetch port and data port, decodes each address onto one of N_MEM_BANKS word-interleaved SRAM banks, and resolves same-bank conflicts with a fairness bit. It routes each one-cycle-latency bank read back to the requester that issued it. It is the stage that directly feeds the single shared instruction/data memory built from N_MEM_BANKS × N_WORDS_BANK words.

---
 rtl/tile_l1_bank_mux.sv | 157 +++++++++++++++
 tb/tb_tile_l1_bank_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_l1_bank_mux.sv
// tile_l1_bank_mux: request-side front end of the banked L1 scratchpad.
// Decodes the instruction-fetch and data ports onto word-interleaved banks,
// arbitrates same-bank conflicts with a toggling fairness bit, and steers the
// one-cycle-latency bank read data back to the port that issued the request.
// Optional feature macro: ADDR_RANGE_CHECK_EN (out-of-range detection, err_o).
module tile_l1_bank_mux #(
   parameter int unsigned N_MEM_BANKS  = 16,
   parameter int unsigned N_WORDS_BANK = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   instr_req_i,
   output logic                                   instr_gnt_o,
   input  logic [31:0]                            instr_addr_i,
   output logic                                   instr_rvalid_o,
   output logic [31:0]                            instr_rdata_o,
   input  logic                                   data_req_i,
   output logic                                   data_gnt_o,
   input  logic                                   data_we_i,
   input  logic [3:0]                             data_be_i,
   input  logic [31:0]                            data_addr_i,
   input  logic [31:0]                            data_wdata_i,
   output logic                                   data_rvalid_o,
   output logic [31:0]                            data_rdata_o,
   output logic [N_MEM_BANKS-1:0]                 bank_req_o,
   output logic [N_MEM_BANKS-1:0]                 bank_we_o,
   output logic [4*N_MEM_BANKS-1:0]               bank_be_o,
   output logic [$clog2(N_WORDS_BANK)*N_MEM_BANKS-1:0] bank_addr_o,
   output logic [32*N_MEM_BANKS-1:0]              bank_wdata_o,
   input  logic [32*N_MEM_BANKS-1:0]              bank_rdata_i,
   output logic                                   err_o
);

   localparam int unsigned BW = $clog2(N_MEM_BANKS);
   localparam int unsigned RW = $clog2(N_WORDS_BANK);
   localparam logic [31:0] OOR_DATA = 32'hBADC_AB1E;

   logic [31:0]   i_off, d_off;
   logic [BW-1:0] i_bank, d_bank;
   logic [RW-1:0] i_row, d_row;
   logic          i_oor, d_oor;
   logic          i_act, d_act;
   logic          i_bank_req, d_bank_req;
   logic          conflict, i_win, d_win;

   logic          prio_q;
   logic          i_pend_q, d_pend_q;
   logic [BW-1:0] i_bank_q, d_bank_q;
   logic          i_oor_q, d_oor_q;
   logic          d_we_q;

   // Address decode: shifting the whole offset keeps the byte and alias bits
   // formally consumed while only the bank/row fields survive the casts.
   assign i_off  = instr_addr_i - BASE_ADDR;
   assign d_off  = data_addr_i - BASE_ADDR;
   assign i_bank = BW'(i_off >> 2);
   assign d_bank = BW'(d_off >> 2);
   assign i_row  = RW'(i_off >> (2 + BW));
   assign d_row  = RW'(d_off >> (2 + BW));

`ifdef ADDR_RANGE_CHECK_EN
   localparam logic [32:0] L1_BYTES = 33'(N_MEM_BANKS) * 33'(N_WORDS_BANK) * 33'd4;
   assign i_oor = ({1'b0, i_off} >= L1_BYTES);
   assign d_oor = ({1'b0, d_off} >= L1_BYTES);
`else
   assign i_oor = 1'b0;
   assign d_oor = 1'b0;
`endif

   // Requests are masked while reset is held so no grant or bank access leaks out.
   assign i_act      = instr_req_i & rst_ni;
   assign d_act      = data_req_i & rst_ni;
   assign i_bank_req = i_act & ~i_oor;
   assign d_bank_req = d_act & ~d_oor;
   assign conflict   = i_bank_req & d_bank_req & (i_bank == d_bank);
   assign i_win      = i_bank_req & (~conflict | prio_q);
   assign d_win      = d_bank_req & (~conflict | ~prio_q);

   assign instr_gnt_o = i_win | (i_act & i_oor);
   assign data_gnt_o  = d_win | (d_act & d_oor);

   // Steer each winning port onto its bank's request lines.
   always_comb begin
      bank_req_o   = '0;
      bank_we_o    = '0;
      bank_be_o    = '0;
      bank_addr_o  = '0;
      bank_wdata_o = '0;
      for (int unsigned b = 0; b < N_MEM_BANKS; b++) begin
         if (d_win && (d_bank == BW'(b))) begin
            bank_req_o[b]          = 1'b1;
            bank_we_o[b]           = data_we_i;
            bank_be_o[4*b +: 4]    = data_be_i;
            bank_addr_o[RW*b +: RW] = d_row;
            bank_wdata_o[32*b +: 32] = data_wdata_i;
         end else if (i_win && (i_bank == BW'(b))) begin
            bank_req_o[b]          = 1'b1;
            bank_be_o[4*b +: 4]    = 4'hF;
            bank_addr_o[RW*b +: RW] = i_row;
         end
      end
   end

   // Fairness bit and per-port response tracking, captured on grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q   <= 1'b0;
         i_pend_q <= 1'b0;
         d_pend_q <= 1'b0;
         i_bank_q <= '0;
         d_bank_q <= '0;
         i_oor_q  <= 1'b0;
         d_oor_q  <= 1'b0;
         d_we_q   <= 1'b0;
      end else begin
         if (conflict) prio_q <= ~prio_q;
         i_pend_q <= instr_gnt_o;
         d_pend_q <= data_gnt_o;
         i_bank_q <= i_bank;
         d_bank_q <= d_bank;
         i_oor_q  <= i_oor;
         d_oor_q  <= d_oor;
         d_we_q   <= data_we_i;
      end
   end

`ifdef ADDR_RANGE_CHECK_EN
   logic err_q;

   // Sticky error flag: any granted out-of-range access sets it until reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_q | (instr_gnt_o & i_oor) | (data_gnt_o & d_oor);
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   // Response data: bank read data selected by the captured bank index.
   always_comb begin
      instr_rvalid_o = i_pend_q;
      data_rvalid_o  = d_pend_q;
      instr_rdata_o  = '0;
      data_rdata_o   = '0;
      if (i_pend_q) begin
         instr_rdata_o = i_oor_q ? OOR_DATA : bank_rdata_i[32*i_bank_q +: 32];
      end
      if (d_pend_q) begin
         if (d_oor_q)     data_rdata_o = OOR_DATA;
         else if (!d_we_q) data_rdata_o = bank_rdata_i[32*d_bank_q +: 32];
      end
   end

endmodule

// File: tb/tb_tile_l1_bank_mux.sv
// tb_tile_l1_bank_mux: directed bench for tile_l1_bank_mux with a simple
// bank model returning 0xA0bb_0rrr (bank bb, row rrr) one cycle after a read.
module tb_tile_l1_bank_mux;

   localparam int NB = 16;
   localparam int RW = 10;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic              instr_req, instr_gnt, instr_rvalid;
   logic [31:0]       instr_addr, instr_rdata;
   logic              data_req, data_gnt, data_we, data_rvalid;
   logic [3:0]        data_be;
   logic [31:0]       data_addr, data_wdata, data_rdata;
   logic [NB-1:0]     bank_req, bank_we;
   logic [4*NB-1:0]   bank_be;
   logic [RW*NB-1:0]  bank_addr;
   logic [32*NB-1:0]  bank_wdata;
   logic [32*NB-1:0]  bank_rdata = '0;
   logic              err;

   int checks = 0;
   int errors = 0;

   tile_l1_bank_mux #(
      .N_MEM_BANKS  (NB),
      .N_WORDS_BANK (1024),
      .BASE_ADDR    (32'h0000_0000)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .instr_req_i    (instr_req),
      .instr_gnt_o    (instr_gnt),
      .instr_addr_i   (instr_addr),
      .instr_rvalid_o (instr_rvalid),
      .instr_rdata_o  (instr_rdata),
      .data_req_i     (data_req),
      .data_gnt_o     (data_gnt),
      .data_we_i      (data_we),
      .data_be_i      (data_be),
      .data_addr_i    (data_addr),
      .data_wdata_i   (data_wdata),
      .data_rvalid_o  (data_rvalid),
      .data_rdata_o   (data_rdata),
      .bank_req_o     (bank_req),
      .bank_we_o      (bank_we),
      .bank_be_o      (bank_be),
      .bank_addr_o    (bank_addr),
      .bank_wdata_o   (bank_wdata),
      .bank_rdata_i   (bank_rdata),
      .err_o          (err)
   );

   always #5 clk = ~clk;

   // Bank model: a read returns a bank/row signature on the following cycle.
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (bank_req[b] && !bank_we[b])
            bank_rdata[32*b +: 32] <= 32'hA000_0000 | (32'(b) << 16) | 32'(bank_addr[RW*b +: RW]);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      rst_ni     = 1'b0;
      instr_req  = 1'b1;
      instr_addr = 32'h0000_0000;
      data_req   = 1'b1;
      data_addr  = 32'h0000_0040;
      data_we    = 1'b0;
      data_be    = 4'hF;
      data_wdata = 32'h0;

      // Reset held with both ports requesting: everything quiet.
      #3;
      check_eq("rst_igNT", 32'(instr_gnt), 32'd0);
      check_eq("rst_dgnt", 32'(data_gnt), 32'd0);
      check_eq("rst_irv", 32'(instr_rvalid), 32'd0);
      check_eq("rst_drv", 32'(data_rvalid), 32'd0);
      check_eq("rst_irdata", instr_rdata, 32'd0);
      check_eq("rst_drdata", data_rdata, 32'd0);
      check_eq("rst_breq", 32'(bank_req), 32'd0);
      check_eq("rst_bwe", 32'(bank_we), 32'd0);
      check_eq("rst_bbe", 32'(|bank_be), 32'd0);
      check_eq("rst_baddr", 32'(|bank_addr), 32'd0);
      check_eq("rst_bwdata", 32'(|bank_wdata), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      check_eq("rst_hold_breq", 32'(bank_req), 32'd0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      #1;

      // Conflict on bank 0: data (row 1) then instr (row 0), alternating.
      for (int c = 0; c < 4; c++) begin
         check_eq($sformatf("fair%0d_dgnt", c), 32'(data_gnt), (c % 2 == 0) ? 32'd1 : 32'd0);
         check_eq($sformatf("fair%0d_ignt", c), 32'(instr_gnt), (c % 2 == 1) ? 32'd1 : 32'd0);
         check_eq($sformatf("fair%0d_breq", c), 32'(bank_req), 32'h0001);
         check_eq($sformatf("fair%0d_row", c), 32'(bank_addr[RW-1:0]), (c % 2 == 0) ? 32'd1 : 32'd0);
         if (c == 0) begin
            check_eq("fair0_drv", 32'(data_rvalid), 32'd0);
            check_eq("fair0_irv", 32'(instr_rvalid), 32'd0);
         end else if (c % 2 == 1) begin
            check_eq($sformatf("fair%0d_drv", c), 32'(data_rvalid), 32'd1);
            check_eq($sformatf("fair%0d_drdata", c), data_rdata, 32'hA000_0001);
            check_eq($sformatf("fair%0d_irv", c), 32'(instr_rvalid), 32'd0);
         end else begin
            check_eq($sformatf("fair%0d_irv", c), 32'(instr_rvalid), 32'd1);
            check_eq($sformatf("fair%0d_irdata", c), instr_rdata, 32'hA000_0000);
            check_eq($sformatf("fair%0d_drv", c), 32'(data_rvalid), 32'd0);
         end
         @(posedge clk); #2;
      end
      check_eq("fair_end_irv", 32'(instr_rvalid), 32'd1);
      check_eq("fair_end_irdata", instr_rdata, 32'hA000_0000);
      check_eq("fair_end_drv", 32'(data_rvalid), 32'd0);

      // No conflict: instr read bank 0 row 1, data write bank 1 row 1.
      instr_addr = 32'h0000_0040;
      data_addr  = 32'h0000_0044;
      data_we    = 1'b1;
      data_wdata = 32'hDEAD_BEEF;
      data_be    = 4'hF;
      #1;
      check_eq("nc_ignt", 32'(instr_gnt), 32'd1);
      check_eq("nc_dgnt", 32'(data_gnt), 32'd1);
      check_eq("nc_breq", 32'(bank_req), 32'h0003);
      check_eq("nc_bwe", 32'(bank_we), 32'h0002);
      check_eq("nc_bbe", 32'(bank_be[7:0]), 32'hFF);
      check_eq("nc_wdata1", bank_wdata[63:32], 32'hDEAD_BEEF);
      check_eq("nc_wdata0", bank_wdata[31:0], 32'h0);
      check_eq("nc_row1", 32'(bank_addr[2*RW-1:RW]), 32'd1);
      @(posedge clk); #1;
      instr_req = 1'b0;
      data_req  = 1'b0;
      data_we   = 1'b0;
      #1;
      check_eq("nc_irv", 32'(instr_rvalid), 32'd1);
      check_eq("nc_irdata", instr_rdata, 32'hA000_0001);
      check_eq("nc_drv", 32'(data_rvalid), 32'd1);
      check_eq("nc_drdata", data_rdata, 32'h0);

      // Back-to-back streaming reads across all 16 banks.
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         data_req  = 1'b1;
         data_addr = 32'(i * 4);
         #1;
         check_eq($sformatf("str%0d_gnt", i), 32'(data_gnt), 32'd1);
         check_eq($sformatf("str%0d_breq", i), 32'(bank_req), 32'd1 << i);
         if (i > 0) begin
            check_eq($sformatf("str%0d_rv", i), 32'(data_rvalid), 32'd1);
            check_eq($sformatf("str%0d_rdata", i), data_rdata, 32'hA000_0000 | (32'(i - 1) << 16));
         end
         @(posedge clk); #1;
      end
      data_req = 1'b0;
      #1;
      check_eq("str_end_rv", 32'(data_rvalid), 32'd1);
      check_eq("str_end_rdata", data_rdata, 32'hA00F_0000);

      // Address just past the 64 KiB L1 region.
      @(posedge clk); #1;
      data_req  = 1'b1;
      data_addr = 32'h0001_0000;
      #1;
      check_eq("oor_gnt", 32'(data_gnt), 32'd1);
`ifdef ADDR_RANGE_CHECK_EN
      check_eq("oor_breq", 32'(bank_req), 32'd0);
`else
      check_eq("oor_breq", 32'(bank_req), 32'h0001);
      check_eq("oor_row", 32'(bank_addr[RW-1:0]), 32'd0);
`endif
      @(posedge clk); #1;
      data_req = 1'b0;
      #1;
      check_eq("oor_rv", 32'(data_rvalid), 32'd1);
`ifdef ADDR_RANGE_CHECK_EN
      check_eq("oor_rdata", data_rdata, 32'hBADC_AB1E);
      check_eq("oor_err", 32'(err), 32'd1);
`else
      check_eq("oor_rdata", data_rdata, 32'hA000_0000);
      check_eq("oor_err", 32'(err), 32'd0);
`endif

      // Mid-op reset: conflict on bank 1 (data wins, prio flips to instr).
      @(posedge clk); #1;
      instr_req  = 1'b1;
      instr_addr = 32'h0000_0004;
      data_req   = 1'b1;
      data_addr  = 32'h0000_0044;
      #1;
      check_eq("mid_dgnt", 32'(data_gnt), 32'd1);
      check_eq("mid_ignt", 32'(instr_gnt), 32'd0);
      @(posedge clk); #1;
      rst_ni    = 1'b0;
      instr_req = 1'b0;
      data_req  = 1'b0;
      #1;
      check_eq("mid_rst_drv", 32'(data_rvalid), 32'd0);
      check_eq("mid_rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      #1;
      check_eq("mid_rel_drv", 32'(data_rvalid), 32'd0);
      check_eq("mid_rel_irv", 32'(instr_rvalid), 32'd0);
      @(posedge clk); #1;
      instr_req  = 1'b1;
      instr_addr = 32'h0000_0000;
      data_req   = 1'b1;
      data_addr  = 32'h0000_0040;
      #1;
      check_eq("post_dgnt", 32'(data_gnt), 32'd1);
      check_eq("post_ignt", 32'(instr_gnt), 32'd0);
      check_eq("post_drv_idle", 32'(data_rvalid), 32'd0);
      @(posedge clk); #1;
      instr_req = 1'b0;
      data_req  = 1'b0;
      #1;
      check_eq("post_drv", 32'(data_rvalid), 32'd1);
      check_eq("post_drdata", data_rdata, 32'hA000_0001);
      check_eq("post_irv", 32'(instr_rvalid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
